// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the immediate decode stage: RV32 opcode constants,
// immediate format codes, skid-buffer state encoding and the buffered entry
// layout.
// No ports (package).
// -----------------------------------------------------------------------------
package decode_pkg;

  localparam int XLEN_SUPPORTED = 32;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    fmt_e        fmt;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{instr: 32'h0, pc: 32'h0, imm: 32'h0, fmt: FMT_R};

endpackage

// File: rtl/imm_decode_stage_if.sv
// -----------------------------------------------------------------------------
// imm_decode_stage_if
// Handshake bundle between fetch, the decode stage and execute.
//   in_valid/in_ready/in_instr/in_pc : instruction offered by fetch
//   flush                            : discard everything held and offered
//   out_valid/out_ready              : decoded entry handed to execute
//   out_instr/out_pc/out_imm/out_fmt : decoded entry contents
// Modports: master = fetch/execute side, slave = decode stage.
// -----------------------------------------------------------------------------
interface imm_decode_stage_if
  import decode_pkg::*;
#(
  parameter int XLEN = 32
);

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_imm;
  fmt_e            out_fmt;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt
  );

endinterface

// File: rtl/ImmGen.sv
// -----------------------------------------------------------------------------
// ImmGen
// Builds the sign-extended RV32 immediate for an already decoded format.
//   instr_hi : instruction bits [31:7] (opcode not needed here)
//   fmt      : immediate format code
//   imm      : 32-bit immediate, zero for R format
// -----------------------------------------------------------------------------
module ImmGen
  import decode_pkg::*;
(
  input  logic [31:7] instr_hi,
  input  fmt_e        fmt,
  output logic [31:0] imm
);

  // Immediate bit shuffling per format.
  always_comb begin
    imm = 32'h0;
    case (fmt)
      FMT_I: imm = {{20{instr_hi[31]}}, instr_hi[31:20]};
      FMT_S: imm = {{20{instr_hi[31]}}, instr_hi[31:25], instr_hi[11:7]};
      FMT_B: imm = {{19{instr_hi[31]}}, instr_hi[31], instr_hi[7], instr_hi[30:25],
                    instr_hi[11:8], 1'b0};
      FMT_U: imm = {instr_hi[31:12], 12'h000};
      FMT_J: imm = {{11{instr_hi[31]}}, instr_hi[31], instr_hi[19:12], instr_hi[20],
                    instr_hi[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// -----------------------------------------------------------------------------
// imm_decode_stage
// Two-entry skid buffer (main + skid) that decodes the immediate and its
// format on capture, so the execute side sees fully registered outputs.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : imm_decode_stage_if.slave (input handshake, flush, output entry)
// -----------------------------------------------------------------------------
module imm_decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32
)(
  input  logic                    clk,
  input  logic                    rst,
  imm_decode_stage_if.slave       bus
);

  state_e      state_r;
  state_e      state_s;
  entry_t      main_r;
  entry_t      skid_r;
  entry_t      in_entry_s;
  logic        in_ready_r;
  logic        out_valid_r;
  logic        accept_s;
  logic        pop_s;
  logic        load_main_in_s;
  logic        load_main_skid_s;
  logic        load_skid_s;
  fmt_e        in_fmt_s;
  logic [31:0] in_imm_s;

  // Format decode from the opcode of the offered instruction.
  always_comb begin
    in_fmt_s = FMT_R;
    case (bus.in_instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: in_fmt_s = FMT_I;
      OPC_STORE:                                  in_fmt_s = FMT_S;
      OPC_BRANCH:                                 in_fmt_s = FMT_B;
      OPC_LUI, OPC_AUIPC:                         in_fmt_s = FMT_U;
      OPC_JAL:                                    in_fmt_s = FMT_J;
      default:                                    in_fmt_s = FMT_R;
    endcase
  end

  ImmGen u_imm_gen (
    .instr_hi (bus.in_instr[31:7]),
    .fmt      (in_fmt_s),
    .imm      (in_imm_s)
  );

  assign in_entry_s = {bus.in_instr, bus.in_pc, in_imm_s, in_fmt_s};
  assign accept_s   = bus.in_valid & in_ready_r;
  assign pop_s      = out_valid_r & bus.out_ready;

  // Next-state and load selects; flush overrides accept and pop.
  always_comb begin
    state_s          = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (bus.flush) begin
      state_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_s        = ST_ONE;
            load_main_in_s = 1'b1;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && pop_s) begin
            state_s        = ST_ONE;
            load_main_in_s = 1'b1;
          end else if (accept_s) begin
            state_s     = ST_FULL;
            load_skid_s = 1'b1;
          end else if (pop_s) begin
            state_s = ST_EMPTY;
          end else begin
            state_s = ST_ONE;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop_s) begin
            state_s          = ST_ONE;
            load_main_skid_s = 1'b1;
          end else begin
            state_s = ST_FULL;
          end
        end
        default: state_s = ST_EMPTY;
      endcase
    end
  end

  // State register with handshake flags precomputed from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s != ST_FULL);
      out_valid_r <= (state_s != ST_EMPTY);
    end
  end

  // Entry storage; contents are left untouched on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_r <= ENTRY_RESET;
      skid_r <= ENTRY_RESET;
    end else begin
      if (load_main_in_s) begin
        main_r <= in_entry_s;
      end else if (load_main_skid_s) begin
        main_r <= skid_r;
      end else begin
        main_r <= main_r;
      end
      if (load_skid_s) begin
        skid_r <= in_entry_s;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_instr = main_r.instr;
  assign bus.out_pc    = main_r.pc;
  assign bus.out_imm   = main_r.imm;
  assign bus.out_fmt   = main_r.fmt;

endmodule

// File: tb/tb_imm_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_decode_stage
// Scoreboard bench: the monitor records every accepted instruction with its
// expected immediate/format from an arithmetic reference model and checks
// each delivered entry in order, plus directed scenarios.
// -----------------------------------------------------------------------------
module tb_imm_decode_stage;
  import decode_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  fmt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  imm_decode_stage_if #(.XLEN(32)) bus ();

  imm_decode_stage #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference: field extraction with plain integer arithmetic.
  function automatic void ref_decode(input logic [31:0] ins, output logic [31:0] imm,
                                     output logic [2:0] fmt);
    longint u;
    longint v;
    int     op;
    u   = longint'({32'h0, ins});
    op  = int'(ins[6:0]);
    v   = 0;
    fmt = FMT_R;
    case (op)
      3, 19, 103, 115: begin
        fmt = FMT_I;
        v = (u >> 20) % 4096;
        if (v >= 2048) v = v - 4096;
      end
      35: begin
        fmt = FMT_S;
        v = ((u >> 25) * 32) + ((u >> 7) % 32);
        if (v >= 2048) v = v - 4096;
      end
      99: begin
        fmt = FMT_B;
        v = ((u >> 31) % 2) * 4096 + ((u >> 7) % 2) * 2048
          + ((u >> 25) % 64) * 32 + ((u >> 8) % 16) * 2;
        if (v >= 4096) v = v - 8192;
      end
      55, 23: begin
        fmt = FMT_U;
        v = u - (u % 4096);
      end
      111: begin
        fmt = FMT_J;
        v = ((u >> 31) % 2) * (1 << 20) + ((u >> 12) % 256) * 4096
          + ((u >> 20) % 2) * 2048 + ((u >> 21) % 1024) * 2;
        if (v >= (1 << 20)) v = v - (1 << 21);
      end
      default: begin
        fmt = FMT_R;
        v = 0;
      end
    endcase
    imm = v[31:0];
  endfunction

  // Monitor: occupancy, in-order delivery, stall stability, capture of accepts.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      check("out_valid_occupancy", 32'(bus.out_valid), 32'(exp_q.size() > 0));
      check("in_ready_occupancy", 32'(bus.in_ready), 32'(exp_q.size() < 2));
      if (bus.out_valid && exp_q.size() > 0) begin
        if (bus.out_ready) begin
          e = exp_q.pop_front();
        end else begin
          e = exp_q[0];
        end
        check("out_instr", bus.out_instr, e.instr);
        check("out_pc", bus.out_pc, e.pc);
        check("out_imm", bus.out_imm, e.imm);
        check("out_fmt", 32'(bus.out_fmt), 32'(e.fmt));
      end
      if (bus.flush) begin
        exp_q.delete();
      end else if (bus.in_valid && bus.in_ready) begin
        e.instr = bus.in_instr;
        e.pc    = bus.in_pc;
        ref_decode(bus.in_instr, e.imm, e.fmt);
        exp_q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = bus.in_ready && !bus.flush;
      step();
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no in_ready, required acceptance within 100 cycles");
    end
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    bus.in_pc    = pc;
    wait_accept();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_out_instr"}, bus.out_instr, 32'h0);
    check({tag, "_out_pc"}, bus.out_pc, 32'h0);
    check({tag, "_out_imm"}, bus.out_imm, 32'h0);
    check({tag, "_out_fmt"}, 32'(bus.out_fmt), 32'(FMT_R));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [12];
    logic [31:0] r;
    ops = '{OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP, OPC_LUI,
            OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM, 7'h0F, 7'h7F};
    r = $urandom();
    return {r[31:7], ops[$urandom_range(0, 11)]};
  endfunction

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0;
    bus.in_pc     = 32'h0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    check_reset_outputs("reset");
    step();
    step();
    rst = 1'b0;
    step();

    // Single ADDI x1,x0,-1 from EMPTY: visible one cycle after acceptance.
    bus.out_ready = 1'b1;
    push(32'hFFF00093, 32'h100);
    check("addi_valid", 32'(bus.out_valid), 32'd1);
    check("addi_imm", bus.out_imm, 32'hFFFFFFFF);
    check("addi_fmt", 32'(bus.out_fmt), 32'(FMT_I));
    check("addi_pc", bus.out_pc, 32'h100);
    bus.in_valid = 1'b0;
    step();

    // LUI then BEQ -4.
    push(32'h12345537, 32'h104);
    check("lui_imm", bus.out_imm, 32'h12345000);
    check("lui_fmt", 32'(bus.out_fmt), 32'(FMT_U));
    push(32'hFE000EE3, 32'h108);
    bus.in_valid = 1'b0;
    check("beq_imm", bus.out_imm, 32'hFFFFFFFC);
    check("beq_fmt", 32'(bus.out_fmt), 32'(FMT_B));
    step();
    step();

    // Back-pressure: two fill the buffer, the third waits at the input.
    bus.out_ready = 1'b0;
    push(32'h00500113, 32'h200);
    push(32'h00A00193, 32'h204);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00F00213;
    bus.in_pc    = 32'h208;
    repeat (3) step();
    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    check("stall_out_instr", bus.out_instr, 32'h00500113);
    bus.out_ready = 1'b1;
    wait_accept();
    bus.in_valid = 1'b0;
    repeat (4) step();

    // Flush while FULL with an input offered.
    bus.out_ready = 1'b0;
    push(32'h00100293, 32'h300);
    push(32'h00200313, 32'h304);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h00300393;
    bus.in_pc    = 32'h308;
    bus.flush    = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    repeat (3) step();

    // Asynchronous reset in the middle of a FULL cycle.
    bus.out_ready = 1'b0;
    push(32'h00400413, 32'h400);
    push(32'h00500493, 32'h404);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    push(32'h00000013, 32'h500);
    check("nop_valid", 32'(bus.out_valid), 32'd1);
    check("nop_imm", bus.out_imm, 32'h0);
    check("nop_fmt", 32'(bus.out_fmt), 32'(FMT_I));

    // R-type ADD.
    push(32'h002081B3, 32'h504);
    bus.in_valid = 1'b0;
    check("rtype_imm", bus.out_imm, 32'h0);
    check("rtype_fmt", 32'(bus.out_fmt), 32'(FMT_R));
    step();

    // Randomized traffic with back-pressure and occasional flush.
    for (int c = 0; c < 800; c++) begin
      bus.in_valid  = ($urandom_range(0, 99) < 60);
      bus.in_instr  = rand_instr();
      bus.in_pc     = $urandom();
      bus.out_ready = ($urandom_range(0, 99) < 55);
      bus.flush     = ($urandom_range(0, 39) == 0);
      step();
    end
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
